// File: rtl/fifo_hex_uart_tx.sv
// Pops 4-bit nibbles from the width-converting FIFO, maps each to an ASCII hex
// character and transmits it as an 8N1 UART frame (LSB first, idle high).
module fifo_hex_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int LOWERCASE    = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       empty,
   input  logic [3:0] r_data,
   output logic       rd,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] LAST    = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] PRELAST = BW'(CLKS_PER_BIT - 2);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [BW-1:0] baud, baud_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shift, shift_n;
   logic          tx_n, busy_n, done_n;

   function automatic logic [7:0] to_ascii(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      else
         return ((LOWERCASE != 0) ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
   endfunction

   assign rd = (state == IDLE) && enable && !empty;

   // Outputs are computed one cycle ahead so tx/busy/tx_done come straight from flops.
   always_comb begin
      state_n   = state;
      baud_n    = baud + BW'(1);
      bit_idx_n = bit_idx;
      shift_n   = shift;
      tx_n      = tx;
      done_n    = 1'b0;
      case (state)
         IDLE: begin
            baud_n = baud;
            tx_n   = 1'b1;
            if (rd) begin
               shift_n = to_ascii(r_data);
               state_n = START;
               baud_n  = '0;
               tx_n    = 1'b0;
            end
         end
         START: begin
            if (baud == LAST) begin
               state_n   = DATA;
               baud_n    = '0;
               bit_idx_n = '0;
               tx_n      = shift[0];
            end
         end
         DATA: begin
            if (baud == LAST) begin
               baud_n = '0;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  shift_n   = shift >> 1;
                  bit_idx_n = bit_idx + 3'd1;
                  tx_n      = shift[1];
               end
            end
         end
         STOP: begin
            // Registered pulse lands in the final STOP cycle.
            if (baud == PRELAST)
               done_n = 1'b1;
            if (baud == LAST) begin
               state_n = IDLE;
               baud_n  = '0;
            end
         end
         default: begin
            state_n = IDLE;
            baud_n  = '0;
            tx_n    = 1'b1;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         tx      <= tx_n;
         busy    <= busy_n;
         tx_done <= done_n;
      end
   end

endmodule

// File: doc/fifo_hex_uart_tx.md
Name: fifo_hex_uart_tx

Overview:
- Downstream consumer of the byte-in/nibble-out width-converting FIFO.
- Pops one 4-bit nibble at a time and converts it to its ASCII hex character ('0'-'9', 'A'-'F').
- Shifts that character out as an 8N1 UART frame on a single serial line, so FIFO contents can be watched on a terminal.
- The FIFO's empty/rd/r_data ports connect directly to this block.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit period; must be >= 2.
- LOWERCASE, 0: 1 maps nibbles 10-15 to 'a'-'f' (0x61-0x66); 0 maps them to 'A'-'F' (0x41-0x46).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = allowed to pop new nibbles; an in-flight frame always completes.
- empty  input  1  FIFO empty flag.
- r_data  input  4  FIFO read data; valid whenever empty=0 (current head entry).
- rd  output  1  FIFO pop strobe, one cycle per nibble.
- tx  output  1  UART serial out; idle high.
- busy  output  1  1 while a frame is in progress (any state other than IDLE).
- tx_done  output  1  one-cycle pulse at end of each frame.

Behaviour:
- Reset (reset=0, takes effect immediately, not waiting for clk):
  - state=IDLE, tx=1, busy=0, tx_done=0, rd=0.
  - Bit counter, baud counter and shift register cleared.
- Reset asserted mid-frame:
  - Frame aborted; tx returns high at once; no tx_done pulse.
  - The already-popped nibble is discarded.
- rd is combinational: rd = (state==IDLE) && enable && !empty. No other condition asserts it.
- IDLE:
  - When rd=1, on that rising edge: latch ascii(r_data) into the 8-bit shift register, go to START, clear baud counter.
  - The FIFO pops on the same edge.
- ASCII map:
  - 0-9 -> 0x30+n.
  - 10-15 -> 0x41+(n-10), or 0x61+(n-10) when LOWERCASE=1.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles, then shift right and increment index.
  - After bit index 7 completes, go to STOP. Data is sent LSB first.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - tx_done=1 in the last cycle of STOP only; next state IDLE.
- Timing:
  - Frame length (START through STOP) is exactly 10*CLKS_PER_BIT cycles.
  - tx changes only on baud-period boundaries; all outputs except rd are registered.
  - Back-to-back: with FIFO non-empty and enable=1, the next rd occurs on the first IDLE cycle, so pop-to-pop spacing is 10*CLKS_PER_BIT+1 cycles.
- enable:
  - enable=0 during a frame does not stop it.
  - It only blocks the next pop. enable is sampled only in IDLE.
- empty:
  - empty=1 in IDLE holds state; no pop, tx stays 1.
  - Changes to empty or r_data outside IDLE are ignored; the character is captured at pop time.
- The block never pops when empty=1, so the FIFO never underflows.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then release with empty=1, enable=1 -> tx=1, rd=0, busy=0 for 500 cycles.
- Digit nibble: r_data=4'h3, empty=0 for exactly one pop -> rd high for 1 cycle, busy rises next edge.
  - tx sequence at CLKS_PER_BIT=16: 0, 1,1,0,0,1,1,0,0, 1 (0x33 LSB first), each bit 16 cycles.
  - tx_done pulse at cycle 160 after pop.
- Letter nibbles:
  - r_data=4'hA -> tx data bits 1,0,0,0,0,0,1,0 (0x41).
  - Same with LOWERCASE=1 -> 0x61, bits 1,0,0,0,0,1,1,0.
- Back-to-back: write byte 8'h80 into the upstream FIFO (nibbles 0x0 then 0x8) -> chars 0x30 then 0x38.
  - Two rd pulses exactly 161 cycles apart; empty=1 after the second pop; tx high afterwards.
- Enable gating: deassert enable mid-frame with FIFO holding 2 nibbles -> current frame completes with tx_done.
  - No further rd until enable=1; the next pop occurs on the first cycle enable is seen high in IDLE.
- Async reset mid-frame: pull reset low during DATA bit 4 between clock edges -> tx=1 and busy=0 before the next clk edge.
  - No tx_done; after release with empty=1, no rd.
